// File: rtl/adc_loopback_responder_if.sv
// Pin bundle between the DAC/ADC timing managers (master) and the loopback
// responder (slave).
//
// Strobe semantics: every strobe is an active-low level. The responder samples
// each strobe into a register and acts one cycle later on the edge it sees.
// DAC side:
//   - A WR rising edge with CS low writes DB into the input register chosen by AB.
//   - LDAC low, held for any cycle, copies both input registers into the output registers.
//   - CLR low clears all four DAC registers.
// ADC side:
//   - A CONVST falling edge starts a conversion.
//   - EOC high means a result is waiting to be read.
//   - An RD falling edge asks for the result. It is presented on D with dOe=1
//     after the read delay and held while RD stays low.
//   - RD rising ends the read and drops EOC.
interface adc_loopback_responder_if;
  logic [7:0] DB;
  logic       CS;
  logic       WR;
  logic       AB;
  logic       LDAC;
  logic       CLR;
  logic       CONVST;
  logic       RD;
  logic [7:0] D;
  logic       dOe;
  logic       EOC;
  logic [7:0] overrun;

  modport master (
    output DB, CS, WR, AB, LDAC, CLR, CONVST, RD,
    input  D, dOe, EOC, overrun
  );

  modport slave (
    input  DB, CS, WR, AB, LDAC, CLR, CONVST, RD,
    output D, dOe, EOC, overrun
  );
endinterface

// File: rtl/adc_loopback_responder.sv
// Loopback stand-in for the DAC/ADC board pair. DAC writes land in A/B
// input/output registers, and ADC conversions return the chosen DAC output code.
// Optional feature macro: ADC_NOISE_EN adds LFSR dither on the sample LSB.
module adc_loopback_responder #(
  parameter int CONV_CYCLES = 8,
  parameter int RD_DELAY    = 2,
  parameter int ADC_CHANNEL = 0
) (
  input  logic                        Clk,
  input  logic                        adcRst,
  adc_loopback_responder_if.slave     bus,
  output logic [1:0]                  dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CONV = 2'd1, S_DONE = 2'd2, S_READ = 2'd3} state_t;

  localparam logic [7:0] CNT_LOAD  = 8'(CONV_CYCLES - 1);
  // Delay counter load for the first READ cycle. Delays of 0 or 1 present D
  // straight from the DONE->READ transition.
  localparam logic [2:0] DCNT_LOAD = 3'((RD_DELAY >= 2) ? (RD_DELAY - 2) : 0);
  localparam bit         FAST_RD   = (RD_DELAY <= 1);

  state_t     state_q, state_d;
  logic       wr_q, wr_p_q, convst_q, convst_p_q, rd_q, rd_p_q;
  logic [7:0] db_q;
  logic       cs_q, ab_q;
  logic [7:0] in_a_q, in_a_d, in_b_q, in_b_d, out_a_q, out_a_d, out_b_q, out_b_d;
  logic [7:0] sample_q, sample_d, cnt_q, cnt_d, overrun_q, overrun_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [7:0] d_q, d_d;
  logic       doe_q, doe_d, eoc_q, eoc_d, ovr_inc;
  logic       wr_rise, convst_fall, rd_fall, rd_rise;
  logic [7:0] chan_out, conv_src;

  assign wr_rise     = wr_q & ~wr_p_q;
  assign convst_fall = convst_p_q & ~convst_q;
  assign rd_fall     = rd_p_q & ~rd_q;
  assign rd_rise     = rd_q & ~rd_p_q;
  assign chan_out    = (ADC_CHANNEL == 1) ? out_b_q : out_a_q;

`ifdef ADC_NOISE_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  // Free-running dither source, taps 8,6,5,4.
  always_ff @(posedge Clk or negedge adcRst) begin
    if (!adcRst) lfsr_q <= 8'h01;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
  assign conv_src = chan_out ^ {7'b0, lfsr_q[0]};
`else
  assign conv_src = chan_out;
`endif

  // DAC register update: CLR wins, and a same-cycle write passes straight to the output on LDAC.
  always_comb begin
    in_a_d  = in_a_q;
    in_b_d  = in_b_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    if (!bus.CLR) begin
      in_a_d  = 8'h00;
      in_b_d  = 8'h00;
      out_a_d = 8'h00;
      out_b_d = 8'h00;
    end else begin
      if (wr_rise && !cs_q) begin
        if (ab_q) in_b_d = db_q;
        else      in_a_d = db_q;
      end
      if (!bus.LDAC) begin
        out_a_d = in_a_d;
        out_b_d = in_b_d;
      end
    end
  end

  // ADC next state: conversion countdown, read delay and overrun detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    sample_d = sample_q;
    ovr_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (convst_fall) begin
          sample_d = conv_src;
          cnt_d    = CNT_LOAD;
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        ovr_inc = convst_fall;
        if (cnt_q == 8'h00) state_d = S_DONE;
        else                cnt_d   = cnt_q - 8'h01;
      end
      S_DONE: begin
        ovr_inc = convst_fall;
        if (rd_fall) begin
          dcnt_d  = DCNT_LOAD;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_rise) begin
          // A start edge landing on the return to idle is accepted, not lost.
          if (convst_fall) begin
            sample_d = conv_src;
            cnt_d    = CNT_LOAD;
            state_d  = S_CONV;
          end else begin
            state_d  = S_IDLE;
          end
        end else begin
          ovr_inc = convst_fall;
          if (dcnt_q != 3'd0) dcnt_d = dcnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    overrun_d = (ovr_inc && overrun_q != 8'hFF) ? overrun_q + 8'h01 : overrun_q;
  end

  // ADC outputs: EOC trails DONE by one cycle, D is zero whenever dOe is low.
  always_comb begin
    d_d   = 8'h00;
    doe_d = 1'b0;
    eoc_d = 1'b0;
    case (state_q)
      S_DONE: begin
        eoc_d = 1'b1;
        if (rd_fall && FAST_RD) begin
          doe_d = 1'b1;
          d_d   = sample_q;
        end
      end
      S_READ: begin
        if (!rd_rise) begin
          eoc_d = 1'b1;
          if (doe_q || dcnt_q == 3'd0) begin
            doe_d = 1'b1;
            d_d   = sample_q;
          end
        end
      end
      default: begin
        d_d   = 8'h00;
        doe_d = 1'b0;
        eoc_d = 1'b0;
      end
    endcase
  end

  // All state registers; everything clears asynchronously on adcRst low.
  always_ff @(posedge Clk or negedge adcRst) begin
    if (!adcRst) begin
      state_q    <= S_IDLE;
      wr_q       <= 1'b0;
      wr_p_q     <= 1'b0;
      convst_q   <= 1'b0;
      convst_p_q <= 1'b0;
      rd_q       <= 1'b0;
      rd_p_q     <= 1'b0;
      db_q       <= 8'h00;
      cs_q       <= 1'b0;
      ab_q       <= 1'b0;
      in_a_q     <= 8'h00;
      in_b_q     <= 8'h00;
      out_a_q    <= 8'h00;
      out_b_q    <= 8'h00;
      sample_q   <= 8'h00;
      cnt_q      <= 8'h00;
      dcnt_q     <= 3'd0;
      overrun_q  <= 8'h00;
      d_q        <= 8'h00;
      doe_q      <= 1'b0;
      eoc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= bus.WR;
      wr_p_q     <= wr_q;
      convst_q   <= bus.CONVST;
      convst_p_q <= convst_q;
      rd_q       <= bus.RD;
      rd_p_q     <= rd_q;
      db_q       <= bus.DB;
      cs_q       <= bus.CS;
      ab_q       <= bus.AB;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      sample_q   <= sample_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      overrun_q  <= overrun_d;
      d_q        <= d_d;
      doe_q      <= doe_d;
      eoc_q      <= eoc_d;
    end
  end

  assign bus.D       = d_q;
  assign bus.dOe     = doe_q;
  assign bus.EOC     = eoc_q;
  assign bus.overrun = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_loopback_responder.sv
// Bench for adc_loopback_responder: one instance converts channel A, a second converts channel B.
module tb_adc_loopback_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic adc_rst;
  always #5 clk = ~clk;

  logic [7:0] db;
  logic       cs, wr, ab, ldac, clr, convst, rd;
  logic [1:0] st0, st1;

  adc_loopback_responder_if bus0 ();
  adc_loopback_responder_if bus1 ();

  assign bus0.DB = db;     assign bus1.DB = db;
  assign bus0.CS = cs;     assign bus1.CS = cs;
  assign bus0.WR = wr;     assign bus1.WR = wr;
  assign bus0.AB = ab;     assign bus1.AB = ab;
  assign bus0.LDAC = ldac; assign bus1.LDAC = ldac;
  assign bus0.CLR = clr;   assign bus1.CLR = clr;
  assign bus0.CONVST = convst; assign bus1.CONVST = convst;
  assign bus0.RD = rd;     assign bus1.RD = rd;

  adc_loopback_responder #(.CONV_CYCLES(8), .RD_DELAY(2), .ADC_CHANNEL(0)) dut0 (
    .Clk(clk), .adcRst(adc_rst), .bus(bus0), .dbg_state_o(st0));
  adc_loopback_responder #(.CONV_CYCLES(8), .RD_DELAY(2), .ADC_CHANNEL(1)) dut1 (
    .Clk(clk), .adcRst(adc_rst), .bus(bus1), .dbg_state_o(st1));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];   // {expected channel-B result, expected channel-A result}

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dac_write(input logic sel, input logic [7:0] data, input logic cs_v);
    cs = cs_v; ab = sel; db = data; wr = 1'b0;
    tick();
    wr = 1'b1;
    tick();
    tick();
    cs = 1'b1;
  endtask

  task automatic ldac_pulse();
    ldac = 1'b0;
    tick();
    ldac = 1'b1;
    tick();
  endtask

  // Drops CONVST and checks EOC latency; with pulses=1 adds three extra falls
  // during CONV (plus an LDAC reload) and one more in DONE.
  task automatic start_conv(input string tag, input bit pulses);
    convst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) convst = 1'b1;
      if (pulses) begin
        if (k == 2 || k == 4 || k == 6) convst = 1'b0;
        if (k == 3 || k == 5 || k == 7) convst = 1'b1;
        if (k == 3) ldac = 1'b0;
        if (k == 4) ldac = 1'b1;
      end
      if (k == 3)  chk({tag, " state_conv"}, 8'(st0), 8'd1);
      if (k == 10) chk({tag, " eoc_early"}, 8'(bus0.EOC), 8'd0);
      if (k == 11) begin
        chk({tag, " eoc_a"}, 8'(bus0.EOC), 8'd1);
        chk({tag, " eoc_b"}, 8'(bus1.EOC), 8'd1);
      end
    end
    if (pulses) begin
      convst = 1'b0;
      tick();
      convst = 1'b1;
      tick();
    end
  endtask

  task automatic read_result(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    rd = 1'b0;
    tick();
    chk({tag, " doe_n1"}, 8'(bus0.dOe), 8'd0);
    tick();
    chk({tag, " doe_n2"}, 8'(bus0.dOe), 8'd0);
    chk({tag, " d_idle"}, bus0.D, 8'h00);
    tick();
    chk({tag, " doe_n3"}, 8'(bus0.dOe), 8'd1);
    chk({tag, " d_a"}, bus0.D, e[7:0]);
    chk({tag, " d_b"}, bus1.D, e[15:8]);
    tick();
    chk({tag, " d_hold"}, bus0.D, e[7:0]);
    rd = 1'b1;
    tick();
    chk({tag, " doe_before_rise"}, 8'(bus0.dOe), 8'd1);
    tick();
    chk({tag, " doe_end"}, 8'(bus1.dOe), 8'd0);
    chk({tag, " eoc_end"}, 8'(bus0.EOC), 8'd0);
    chk({tag, " d_end"}, bus0.D, 8'h00);
    chk({tag, " state_idle"}, 8'(st0), 8'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " d"}, bus0.D, 8'h00);
    chk({tag, " doe"}, 8'(bus0.dOe), 8'd0);
    chk({tag, " eoc"}, 8'(bus0.EOC), 8'd0);
    chk({tag, " ovr_a"}, bus0.overrun, 8'h00);
    chk({tag, " ovr_b"}, bus1.overrun, 8'h00);
    chk({tag, " state"}, 8'(st1), 8'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cs_b;   // CS level used for the B write (1 = write ignored)
    logic       do_a2;  // write A again without LDAC after the load
    logic [7:0] a2;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 8'h5A, b: 8'h11, cs_b: 1'b0, do_a2: 1'b0, a2: 8'h00, exp_a: 8'h5A, exp_b: 8'h11};
    vecs[1] = '{a: 8'h33, b: 8'h22, cs_b: 1'b0, do_a2: 1'b1, a2: 8'hC0, exp_a: 8'h33, exp_b: 8'h22};
    vecs[2] = '{a: 8'h7E, b: 8'h81, cs_b: 1'b0, do_a2: 1'b0, a2: 8'h00, exp_a: 8'h7E, exp_b: 8'h81};
    vecs[3] = '{a: 8'h3C, b: 8'hFF, cs_b: 1'b1, do_a2: 1'b0, a2: 8'h00, exp_a: 8'h3C, exp_b: 8'h81};
    vecs[4] = '{a: 8'hFF, b: 8'h00, cs_b: 1'b0, do_a2: 1'b0, a2: 8'h00, exp_a: 8'hFF, exp_b: 8'h00};

    db = 8'h00; cs = 1'b1; wr = 1'b1; ab = 1'b0; ldac = 1'b1; clr = 1'b1;
    convst = 1'b1; rd = 1'b1; adc_rst = 1'b0;
    tick(); tick(); tick();
    chk_reset("reset");
    adc_rst = 1'b1;
    tick(); tick();

    // Table-driven write / load / convert / read
    for (int i = 0; i < 5; i++) begin
      dac_write(1'b0, vecs[i].a, 1'b0);
      dac_write(1'b1, vecs[i].b, vecs[i].cs_b);
      ldac_pulse();
      if (vecs[i].do_a2) dac_write(1'b0, vecs[i].a2, 1'b0);
      exp_q.push_back({vecs[i].exp_b, vecs[i].exp_a});
      start_conv($sformatf("vec%0d", i), 1'b0);
      read_result($sformatf("vec%0d", i));
    end
    chk("overrun_none", bus0.overrun, 8'h00);

    // Read aborted before the delay elapses: dOe never rises, EOC drops
    start_conv("abort", 1'b0);
    rd = 1'b0;
    tick();
    chk("abort doe1", 8'(bus0.dOe), 8'd0);
    rd = 1'b1;
    tick();
    chk("abort doe2", 8'(bus0.dOe), 8'd0);
    tick();
    chk("abort doe3", 8'(bus0.dOe), 8'd0);
    tick();
    chk("abort doe4", 8'(bus0.dOe), 8'd0);
    chk("abort eoc", 8'(bus0.EOC), 8'd0);
    chk("abort state", 8'(st0), 8'd0);

    // RD falling while idle is ignored
    rd = 1'b0;
    tick(); tick(); tick();
    chk("idle_rd state", 8'(st0), 8'd0);
    chk("idle_rd doe", 8'(bus0.dOe), 8'd0);
    rd = 1'b1;
    tick(); tick();

    // Overrun: 3 falls in CONV, 1 in DONE; result from the first edge only
    dac_write(1'b0, 8'hA5, 1'b0);
    dac_write(1'b1, 8'h5B, 1'b0);
    exp_q.push_back({8'h00, 8'hFF});
    start_conv("ovr", 1'b1);
    read_result("ovr");
    chk("ovr count_a", bus0.overrun, 8'd4);
    chk("ovr count_b", bus1.overrun, 8'd4);

    // CLR held during a WR edge wipes everything
    dac_write(1'b0, 8'hAA, 1'b0);
    ldac_pulse();
    cs = 1'b0; ab = 1'b0; db = 8'h55; wr = 1'b0;
    tick();
    wr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    clr = 1'b1; cs = 1'b1;
    tick();
    exp_q.push_back({8'h00, 8'h00});
    start_conv("clr", 1'b0);
    read_result("clr");
    ldac_pulse();
    exp_q.push_back({8'h00, 8'h00});
    start_conv("clr_ld", 1'b0);
    read_result("clr_ld");

    // Reset in the middle of a conversion
    dac_write(1'b0, 8'h5A, 1'b0);
    ldac_pulse();
    convst = 1'b0;
    tick();
    convst = 1'b1;
    tick(); tick();
    chk("rst_conv pre", 8'(st0), 8'd1);
    adc_rst = 1'b0;
    #1;
    chk_reset("rst_conv");
    tick(); tick();
    adc_rst = 1'b1;
    tick(); tick();
    exp_q.push_back({8'h00, 8'h00});
    start_conv("post_rst1", 1'b0);
    read_result("post_rst1");

    // Reset in the middle of a read
    dac_write(1'b0, 8'h5A, 1'b0);
    ldac_pulse();
    start_conv("rst_read", 1'b0);
    rd = 1'b0;
    tick(); tick(); tick();
    chk("rst_read doe_pre", 8'(bus0.dOe), 8'd1);
    chk("rst_read d_pre", bus0.D, 8'h5A);
    adc_rst = 1'b0;
    #1;
    chk_reset("rst_read");
    rd = 1'b1;
    tick(); tick();
    adc_rst = 1'b1;
    tick(); tick();
    exp_q.push_back({8'h00, 8'h00});
    start_conv("post_rst2", 1'b0);
    read_result("post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- final report on runaway ----------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
